// File: rtl/match_scoreboard_if.sv
// match_scoreboard_if
//   Groups the round-result inputs and the scoreboard outputs of
//   match_scoreboard into one bundle.
//   Signals:
//     p1_win, p2_win  round-win levels from the winner display
//     round_reset     reset request to the light chain and the winner display
//     hex_p1, hex_p2  active-low gfedcba score digits
//     match_over      high once a player has reached the winning score
//     winner          00 none, 01 player 1, 10 player 2
//   Modports:
//     master  drives the win levels and observes the outputs (bench or upstream)
//     slave   the scoreboard itself
interface match_scoreboard_if;
  logic       p1_win;
  logic       p2_win;
  logic       round_reset;
  logic [6:0] hex_p1;
  logic [6:0] hex_p2;
  logic       match_over;
  logic [1:0] winner;

  modport master (
    output p1_win, p2_win,
    input  round_reset, hex_p1, hex_p2, match_over, winner
  );

  modport slave (
    input  p1_win, p2_win,
    output round_reset, hex_p1, hex_p2, match_over, winner
  );
endinterface

// File: rtl/match_scoreboard.sv
// match_scoreboard
//   Keeps the match score for the tug-of-war game. Each rising edge of a
//   round-win level scores one point. The round result is then held for
//   HOLD_CYCLES cycles, and a one-cycle round_reset pulse restarts the round.
//   When a player reaches MAX_SCORE the match ends: round_reset stays high
//   and the winner is reported until reset.
//   Ports:
//     clk_i  system clock
//     rst_i  synchronous, active-high; clears the whole match
//     bus    match_scoreboard_if.slave (win levels in, digits and status out)
//
//   state | meaning
//   ------+-------------------------------------------------------
//   PLAY  | waiting for a round-win rise
//   HOLD  | showing the round result for HOLD_CYCLES cycles
//   CLEAR | one-cycle round_reset pulse, then back to PLAY
//   DONE  | match won; round_reset held high until reset
module match_scoreboard #(
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  match_scoreboard_if.slave  bus
);

  localparam int         CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0] MAX_S     = 3'(MAX_SCORE);
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    HOLD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      score1_q, score1_d;
  logic [2:0]      score2_q, score2_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            prev_p1_q, prev_p2_q;
  logic            rise_p1, rise_p2;
  logic            round_reset_q;
  logic            match_over_q;
  logic [1:0]      winner_q;
  logic [6:0]      hex_p1_q, hex_p2_q;

  function automatic logic [6:0] seg7(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'b1000000;
      3'd1:    s = 7'b1111001;
      3'd2:    s = 7'b0100100;
      3'd3:    s = 7'b0110000;
      3'd4:    s = 7'b0011001;
      3'd5:    s = 7'b0010010;
      3'd6:    s = 7'b0000010;
      default: s = 7'b1111000;
    endcase
    return s;
  endfunction

  assign rise_p1 = bus.p1_win & ~prev_p1_q;
  assign rise_p2 = bus.p2_win & ~prev_p2_q;

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    cnt_d    = cnt_q;
    case (state_q)
      PLAY: begin
        if (rise_p1 || rise_p2) begin
          state_d = HOLD;
          cnt_d   = '0;
          // a simultaneous rise is a draw and scores nobody
          if (rise_p1 && !rise_p2 && score1_q != MAX_S)
            score1_d = score1_q + 3'd1;
          if (rise_p2 && !rise_p1 && score2_q != MAX_S)
            score2_d = score2_q + 3'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          if (score1_q == MAX_S || score2_q == MAX_S)
            state_d = DONE;
          else
            state_d = CLEAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR:   state_d = PLAY;
      DONE:    state_d = DONE;
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // the edge detector tracks the inputs through reset so a level held
    // across reset release is not counted as a new win
    prev_p1_q <= bus.p1_win;
    prev_p2_q <= bus.p2_win;
    if (rst_i) begin
      state_q       <= PLAY;
      score1_q      <= '0;
      score2_q      <= '0;
      cnt_q         <= '0;
      round_reset_q <= 1'b0;
      match_over_q  <= 1'b0;
      winner_q      <= 2'b00;
      hex_p1_q      <= SEG_ZERO;
      hex_p2_q      <= SEG_ZERO;
    end else begin
      state_q       <= state_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      cnt_q         <= cnt_d;
      // status outputs follow the state being entered, so the pulse lines up
      // with the CLEAR cycle itself
      round_reset_q <= (state_d == CLEAR) || (state_d == DONE);
      match_over_q  <= (state_d == DONE);
      if (state_d == DONE)
        winner_q <= (score1_q == MAX_S) ? 2'b01 : 2'b10;
      else
        winner_q <= 2'b00;
      hex_p1_q      <= seg7(score1_q);
      hex_p2_q      <= seg7(score2_q);
    end
  end

  assign bus.round_reset = round_reset_q;
  assign bus.match_over  = match_over_q;
  assign bus.winner      = winner_q;
  assign bus.hex_p1      = hex_p1_q;
  assign bus.hex_p2      = hex_p2_q;

endmodule
